range_dispatcher: RTL and testbench

- Scheduler in front of NUM_UNITS id_finder instances for the day-2 ID search.
- Accepts a stream of [start,end] ID ranges and splits wide ranges into chunks of at most MAX_SPAN IDs.
- Hands each chunk to a free unit using round-robin arbitration, sequences each unit's load/en/done, and reduces the per-unit sums into one job result.
- Replaces the shared load/en and adder cascade with per-unit control.

---
 rtl/day2_pkg.sv | 34 +++
 rtl/range_dispatcher_rr_arbiter.sv | 31 +++
 rtl/range_dispatcher.sv | 174 +++++++++++++++++
 tb/tb_range_dispatcher.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/day2_pkg.sv
// Shared types and chunking helper for the day-2 range dispatcher.
package day2_pkg;

    localparam int SUM_W = 48;
    localparam int ERR_W = 16;

    typedef enum logic [2:0] {
        T_IDLE,
        T_RUN,
        T_DRAIN,
        T_REDUCE,
        T_RESULT
    } top_state_t;

    typedef enum logic [1:0] {
        U_FREE,
        U_LOAD,
        U_RUN
    } unit_state_t;

    // Compare the remaining width rather than cs+span so the top ID cannot wrap.
    function automatic logic [63:0] chunk_end(
        input logic [63:0] cs,
        input logic [63:0] ce,
        input logic [63:0] span
    );
        logic [63:0] r;
        r = ce;
        if (ce - cs >= span)
            r = cs + span - 64'd1;
        return r;
    endfunction

endpackage

// File: rtl/range_dispatcher_rr_arbiter.sv
// Round-robin grant: first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    always_comb begin
        int j;
        logic [IW-1:0] jj;
        grant     = '0;
        grant_idx = '0;
        // Scan from farthest to nearest so the nearest requester wins.
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N)
                j = j - N;
            jj = IW'(j);
            if (req[jj]) begin
                grant     = '0;
                grant[jj] = 1'b1;
                grant_idx = jj;
            end
        end
    end

endmodule

// File: rtl/range_dispatcher.sv
// Splits ID ranges into chunks, dispatches them round-robin to id_finder
// units, and reduces the per-unit sums into one job result.
module range_dispatcher
    import day2_pkg::*;
#(
    parameter int              W         = SUM_W,
    parameter int              NUM_UNITS = 8,
    parameter longint unsigned MAX_SPAN  = 64'd1048576
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_start,
    input  logic [W-1:0]           in_end,
    input  logic                   in_last,
    output logic [NUM_UNITS-1:0]   unit_load,
    output logic [NUM_UNITS-1:0]   unit_en,
    output logic [NUM_UNITS-1:0]   unit_clr,
    output logic [NUM_UNITS*W-1:0] unit_start,
    output logic [NUM_UNITS*W-1:0] unit_end,
    input  logic [NUM_UNITS-1:0]   unit_done,
    input  logic [NUM_UNITS*W-1:0] unit_sum,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [W-1:0]           res_sum,
    output logic                   busy,
    output logic [ERR_W-1:0]       err_count
);

    localparam int          IW   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam logic [63:0] SPAN = 64'(MAX_SPAN);

    top_state_t  st_q, st_d;
    unit_state_t ust_q [NUM_UNITS];
    unit_state_t ust_d [NUM_UNITS];

    logic                   hv_q, last_q;
    logic [W-1:0]           cs_q, ce_q, acc_q;
    logic [IW-1:0]          ptr_q, ridx_q;
    logic [ERR_W-1:0]       err_q;
    logic [NUM_UNITS*W-1:0] ustart_q, uend_q;

    logic                 accept, drop, dispatch, granted, c_last;
    logic [W-1:0]         c_end;
    logic [NUM_UNITS-1:0] free, req, grant;
    logic [IW-1:0]        grant_idx;

    always_comb begin
        for (int i = 0; i < NUM_UNITS; i++)
            free[i] = (ust_q[i] == U_FREE);
    end

    assign accept   = in_valid & in_ready;
    assign drop     = in_start > in_end;
    assign dispatch = hv_q & (st_q == T_RUN);
    assign req      = free & {NUM_UNITS{dispatch}};
    assign granted  = |grant;
    assign c_end    = W'(chunk_end(64'(cs_q), 64'(ce_q), SPAN));
    assign c_last   = (c_end == ce_q);

    rr_arbiter #(.N(NUM_UNITS), .IW(IW)) u_arb (
        .req       (req),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st_q <= T_IDLE;
            for (int i = 0; i < NUM_UNITS; i++)
                ust_q[i] <= U_FREE;
        end else begin
            st_q <= st_d;
            for (int i = 0; i < NUM_UNITS; i++)
                ust_q[i] <= ust_d[i];
        end
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            T_IDLE:   if (in_valid) st_d = T_RUN;
            T_RUN:    if (last_q && !hv_q) st_d = T_DRAIN;
            T_DRAIN:  if (&free) st_d = T_REDUCE;
            T_REDUCE: if (ridx_q == IW'(NUM_UNITS - 1)) st_d = T_RESULT;
            T_RESULT: if (res_ready) st_d = T_IDLE;
            default:  st_d = T_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            ust_d[i] = ust_q[i];
            unique case (ust_q[i])
                U_FREE:  if (grant[i]) ust_d[i] = U_LOAD;
                U_LOAD:  ust_d[i] = U_RUN;
                U_RUN:   if (unit_done[i]) ust_d[i] = U_FREE;
                default: ust_d[i] = U_FREE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hv_q     <= 1'b0;
            last_q   <= 1'b0;
            cs_q     <= '0;
            ce_q     <= '0;
            acc_q    <= '0;
            ptr_q    <= '0;
            ridx_q   <= '0;
            err_q    <= '0;
            ustart_q <= '0;
            uend_q   <= '0;
        end else begin
            if (accept) begin
                if (in_last)
                    last_q <= 1'b1;
                if (drop) begin
                    if (err_q != '1)
                        err_q <= err_q + 1'b1;
                end else begin
                    hv_q <= 1'b1;
                    cs_q <= in_start;
                    ce_q <= in_end;
                end
            end else if (granted) begin
                if (c_last)
                    hv_q <= 1'b0;
                else
                    cs_q <= c_end + 1'b1;
                ptr_q <= (grant_idx == IW'(NUM_UNITS - 1)) ?
                         '0 : grant_idx + 1'b1;
            end
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (grant[i]) begin
                    ustart_q[i*W +: W] <= cs_q;
                    uend_q[i*W +: W]   <= c_end;
                end
            end
            if (st_q == T_DRAIN && st_d == T_REDUCE) begin
                acc_q  <= '0;
                ridx_q <= '0;
            end else if (st_q == T_REDUCE) begin
                acc_q  <= acc_q + unit_sum[int'(ridx_q)*W +: W];
                ridx_q <= ridx_q + 1'b1;
            end
            if (st_q == T_RESULT && res_ready)
                last_q <= 1'b0;
        end
    end

    // Clear is only offered from IDLE, where every unit is already free.
    assign in_ready = reset && (st_q == T_IDLE || st_q == T_RUN)
                      && !hv_q && !last_q;
    assign unit_clr = {NUM_UNITS{reset && st_q == T_IDLE && in_valid}};

    always_comb begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            unit_load[i] = (ust_q[i] == U_LOAD);
            unit_en[i]   = (ust_q[i] == U_RUN);
        end
    end

    assign unit_start = ustart_q;
    assign unit_end   = uend_q;
    assign res_valid  = (st_q == T_RESULT);
    assign res_sum    = res_valid ? acc_q : '0;
    assign busy       = (st_q != T_IDLE);
    assign err_count  = err_q;

endmodule

// File: tb/tb_range_dispatcher.sv
// Directed bench for range_dispatcher with behavioural id_finder units.
module tb_range_dispatcher;

    localparam int W  = 48;
    localparam int NA = 8;
    localparam int NB = 2;
    localparam logic [W-1:0] TOP = {W{1'b1}};

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic            a_in_valid = 0, a_in_last = 0, a_res_ready = 0;
    logic [W-1:0]    a_in_start = '0, a_in_end = '0;
    logic            a_in_ready, a_res_valid, a_busy;
    logic [W-1:0]    a_res_sum;
    logic [15:0]     a_err;
    logic [NA-1:0]   a_load, a_en, a_clr, a_done;
    logic [NA*W-1:0] a_start, a_end, a_sum;
    longint unsigned a_acc [NA] = '{default: 0};
    int              a_cnt [NA] = '{default: 0};
    int              a_lat = 2;
    int              a_loads = 0;
    bit              clr_viol = 0;

    logic            b_in_valid = 0, b_in_last = 0, b_res_ready = 0;
    logic [W-1:0]    b_in_start = '0, b_in_end = '0;
    logic            b_in_ready, b_res_valid, b_busy;
    logic [W-1:0]    b_res_sum;
    logic [15:0]     b_err;
    logic [NB-1:0]   b_load, b_en, b_clr, b_done;
    logic [NB*W-1:0] b_start, b_end, b_sum;
    longint unsigned b_acc [NB] = '{default: 0};
    int              b_cnt [NB] = '{default: 0};
    int              b_lat [NB] = '{3, 10};

    typedef struct {
        int           unit;
        logic [W-1:0] s;
        logic [W-1:0] e;
        int           cyc;
    } ld_t;
    ld_t blog [$];
    int  bdone0 [$];

    range_dispatcher #(.W(W), .NUM_UNITS(NA), .MAX_SPAN(64'd1048576)) dut_a (
        .clock(clock), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_start(a_in_start), .in_end(a_in_end), .in_last(a_in_last),
        .unit_load(a_load), .unit_en(a_en), .unit_clr(a_clr),
        .unit_start(a_start), .unit_end(a_end),
        .unit_done(a_done), .unit_sum(a_sum),
        .res_valid(a_res_valid), .res_ready(a_res_ready),
        .res_sum(a_res_sum), .busy(a_busy), .err_count(a_err)
    );

    range_dispatcher #(.W(W), .NUM_UNITS(NB), .MAX_SPAN(64'd4)) dut_b (
        .clock(clock), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_start(b_in_start), .in_end(b_in_end), .in_last(b_in_last),
        .unit_load(b_load), .unit_en(b_en), .unit_clr(b_clr),
        .unit_start(b_start), .unit_end(b_end),
        .unit_done(b_done), .unit_sum(b_sum),
        .res_valid(b_res_valid), .res_ready(b_res_ready),
        .res_sum(b_res_sum), .busy(b_busy), .err_count(b_err)
    );

    // Invalid ID: decimal digits are one block repeated at least twice.
    function automatic bit is_invalid(input longint unsigned n);
        int d [20];
        int len = 0;
        bit ok;
        do begin
            d[len] = int'(n % 10);
            n = n / 10;
            len++;
        end while (n != 0);
        for (int p = 1; p <= len / 2; p++) begin
            if (len % p == 0) begin
                ok = 1;
                for (int k = p; k < len; k++)
                    if (d[k] != d[k-p]) ok = 0;
                if (ok) return 1;
            end
        end
        return 0;
    endfunction

    function automatic longint unsigned csum(input longint unsigned s,
                                             input longint unsigned e);
        longint unsigned t = 0;
        longint unsigned v = s;
        while (1) begin
            if (is_invalid(v)) t += v;
            if (v >= e) break;
            v++;
        end
        return t;
    endfunction

    always_comb begin
        for (int i = 0; i < NA; i++) begin
            a_done[i]        = (a_cnt[i] == 0);
            a_sum[i*W +: W]  = a_acc[i][W-1:0];
        end
        for (int i = 0; i < NB; i++) begin
            b_done[i]        = (b_cnt[i] == 0);
            b_sum[i*W +: W]  = b_acc[i][W-1:0];
        end
    end

    always @(posedge clock) begin
        for (int i = 0; i < NA; i++) begin
            if (a_clr[i]) a_acc[i] <= 0;
            else if (a_load[i])
                a_acc[i] <= a_acc[i] + csum(a_start[i*W +: W], a_end[i*W +: W]);
            if (a_load[i]) a_cnt[i] <= a_lat;
            else if (a_en[i] && a_cnt[i] != 0) a_cnt[i] <= a_cnt[i] - 1;
        end
        for (int i = 0; i < NB; i++) begin
            if (b_clr[i]) b_acc[i] <= 0;
            else if (b_load[i])
                b_acc[i] <= b_acc[i] + csum(b_start[i*W +: W], b_end[i*W +: W]);
            if (b_load[i]) b_cnt[i] <= b_lat[i];
            else if (b_en[i] && b_cnt[i] != 0) b_cnt[i] <= b_cnt[i] - 1;
        end
    end

    always @(negedge clock) begin
        cyc++;
        a_loads += $countones(a_load);
        if (|a_clr && (|a_en || |a_load)) clr_viol = 1;
        for (int i = 0; i < NB; i++)
            if (b_load[i])
                blog.push_back('{i, b_start[i*W +: W], b_end[i*W +: W], cyc});
        if (b_en[0] && b_done[0]) bdone0.push_back(cyc);
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timeout waiting for DUT", nm);
    endtask

    task automatic send_a(input logic [W-1:0] s, input logic [W-1:0] e,
                          input logic l);
        int n = 0;
        @(negedge clock);
        a_in_valid = 1; a_in_start = s; a_in_end = e; a_in_last = l;
        while (!a_in_ready && n < 500) begin @(negedge clock); n++; end
        if (!a_in_ready) begin
            timeout("send_a");
            a_in_valid = 0;
            return;
        end
        @(posedge clock);
        #1 a_in_valid = 0;
    endtask

    task automatic send_b(input logic [W-1:0] s, input logic [W-1:0] e,
                          input logic l);
        int n = 0;
        @(negedge clock);
        b_in_valid = 1; b_in_start = s; b_in_end = e; b_in_last = l;
        while (!b_in_ready && n < 500) begin @(negedge clock); n++; end
        if (!b_in_ready) begin
            timeout("send_b");
            b_in_valid = 0;
            return;
        end
        @(posedge clock);
        #1 b_in_valid = 0;
    endtask

    task automatic wait_res_a(input string nm, input logic [W-1:0] sum,
                              input logic [15:0] err, input bit hold);
        int n = 0;
        bit stable = 1;
        while (!a_res_valid && n < 3000) begin @(negedge clock); n++; end
        if (!a_res_valid) begin timeout({nm, " result"}); return; end
        chk({nm, " sum"}, a_res_sum, sum);
        chk({nm, " err"}, a_err, err);
        if (hold) begin
            repeat (20) begin
                @(negedge clock);
                if (!a_res_valid || a_res_sum !== sum || a_in_ready)
                    stable = 0;
            end
            chk({nm, " hold stable"}, stable, 1);
        end
        a_res_ready = 1;
        @(posedge clock);
        #1 a_res_ready = 0;
        @(negedge clock);
        chk({nm, " idle busy/valid"}, {a_busy, a_res_valid}, 0);
        chk({nm, " idle ready"}, a_in_ready, 1);
    endtask

    task automatic wait_res_b(input string nm, input logic [W-1:0] sum);
        int n = 0;
        while (!b_res_valid && n < 3000) begin @(negedge clock); n++; end
        if (!b_res_valid) begin timeout({nm, " result"}); return; end
        chk({nm, " sum"}, b_res_sum, sum);
        b_res_ready = 1;
        @(posedge clock);
        #1 b_res_ready = 0;
        @(negedge clock);
    endtask

    task automatic chk_ld(input string nm, input int idx, input int unit,
                          input logic [W-1:0] s, input logic [W-1:0] e);
        if (idx >= blog.size()) begin
            timeout({nm, " missing load"});
            return;
        end
        chk({nm, " unit"}, blog[idx].unit, unit);
        chk({nm, " start"}, blog[idx].s, s);
        chk({nm, " end"}, blog[idx].e, e);
    endtask

    typedef struct {
        logic [W-1:0] s0, e0;
        bit           two;
        logic [W-1:0] s1, e1;
        logic [W-1:0] sum;
        logic [15:0]  err;
        int           loads;
        bit           hold;
    } job_t;

    initial begin
        job_t jobs [6];
        int   n0, la, n, dcyc;

        jobs[0] = '{48'd11, 48'd22, 0, 48'd0, 48'd0, 48'd33, 16'd0, 1, 0};
        jobs[1] = '{48'd10, 48'd5, 1, 48'd95, 48'd115, 48'd210, 16'd1, 1, 1};
        jobs[2] = '{48'd1000, 48'd1020, 0, 48'd0, 48'd0, 48'd1010, 16'd1, 1, 0};
        jobs[3] = '{48'd7, 48'd3, 0, 48'd0, 48'd0, 48'd0, 16'd2, 0, 0};
        jobs[4] = '{48'd0, 48'd30, 0, 48'd0, 48'd0, 48'd33, 16'd2, 1, 0};
        jobs[5] = '{48'd1188511880, 48'd1188511890, 0, 48'd0, 48'd0,
                    48'd1188511885, 16'd2, 1, 0};

        #2 reset = 0;
        repeat (3) @(negedge clock);
        chk("rst busy/valid", {a_busy, a_res_valid, b_busy, b_res_valid}, 0);
        chk("rst in_ready", {a_in_ready, b_in_ready}, 0);
        chk("rst err", a_err, 0);
        chk("rst unit ctl", {a_load, a_en, a_clr}, 0);
        chk("rst res_sum", a_res_sum, 0);
        reset = 1;
        @(negedge clock);

        for (int j = 0; j < 6; j++) begin
            la = a_loads;
            if (jobs[j].two) begin
                send_a(jobs[j].s0, jobs[j].e0, 0);
                send_a(jobs[j].s1, jobs[j].e1, 1);
            end else begin
                send_a(jobs[j].s0, jobs[j].e0, 1);
            end
            wait_res_a($sformatf("job%0d", j), jobs[j].sum, jobs[j].err,
                       jobs[j].hold);
            chk($sformatf("job%0d loads", j), a_loads - la, jobs[j].loads);
        end

        n0 = blog.size();
        send_b(48'd0, 48'd9, 1);
        wait_res_b("split", 48'd0);
        chk("split count", blog.size() - n0, 3);
        chk_ld("split c0", n0, 0, 48'd0, 48'd3);
        chk_ld("split c1", n0 + 1, 1, 48'd4, 48'd7);
        chk_ld("split c2", n0 + 2, 0, 48'd8, 48'd9);
        if (blog.size() >= n0 + 3) begin
            dcyc = -1;
            foreach (bdone0[k])
                if (dcyc < 0 && bdone0[k] > blog[n0].cyc) dcyc = bdone0[k];
            chk("regrant after done",
                dcyc > 0 && dcyc < blog[n0+2].cyc, 1);
        end

        n0 = blog.size();
        send_b(TOP - 48'd5, TOP, 1);
        wait_res_b("top", 48'd0);
        chk("top count", blog.size() - n0, 2);
        chk_ld("top c0", n0, 1, TOP - 48'd5, TOP - 48'd2);
        chk_ld("top c1", n0 + 1, 0, TOP - 48'd1, TOP);

        n0 = blog.size();
        send_b(TOP - 48'd3, TOP, 1);
        wait_res_b("top exact", 48'd0);
        chk("top exact count", blog.size() - n0, 1);
        chk_ld("top exact c0", n0, 1, TOP - 48'd3, TOP);

        a_lat = 60;
        send_a(48'd95, 48'd115, 0);
        send_a(48'd11, 48'd22, 0);
        send_a(48'd1000, 48'd1020, 0);
        n = 0;
        while ($countones(a_en) != 3 && n < 50) begin @(negedge clock); n++; end
        if ($countones(a_en) != 3) timeout("three busy");
        reset = 0;
        #1;
        chk("mid rst en", a_en, 0);
        chk("mid rst busy/valid", {a_busy, a_res_valid}, 0);
        chk("mid rst err", a_err, 0);
        @(negedge clock);
        reset = 1;
        a_lat = 2;
        send_a(48'd11, 48'd22, 1);
        wait_res_a("after rst", 48'd33, 16'd0, 0);

        chk("clr while busy", clr_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
